// File: rtl/glyph_pixel_streamer.sv
// glyph_pixel_streamer
// --------------------
// Fetches one GLYPH_H x GLYPH_W character bitmap from the glyph ROM and
// streams it out one pixel per handshake, row-major, with row/column tags.
//
// Handshake rules (both interfaces):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer does not change its payload while valid is high and
//   ready is low.
//
// Ports:
//   clk, rst      : single rising-edge clock, asynchronous active-high reset
//   req_valid     : character request valid (from the character queue)
//   req_ready     : registered; high only while idle and able to accept
//   req_code      : character code, sampled on the request handshake
//   rom_address   : registered glyph ROM address (zero-extended code)
//   rom_data      : GLYPH_W*GLYPH_H-bit ROM word for rom_address
//   pix_valid     : a pixel is presented (EMIT state)
//   pix_ready     : consumer accepts the presented pixel
//   pix_on        : pixel value, 1 = foreground
//   pix_col       : column of the presented pixel
//   pix_row       : row of the presented pixel
//   pix_last      : presented pixel is the bottom-right one
//   busy          : high while fetching or emitting
module glyph_pixel_streamer #(
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_GLYPHS = 26,
  parameter int ROM_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [4:0]                 req_code,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_on,
  output logic [3:0]                 pix_col,
  output logic [4:0]                 pix_row,
  output logic                       pix_last,
  output logic                       busy
);

  localparam int PIX_N = GLYPH_W * GLYPH_H;

  localparam logic [1:0] FETCH_LAST = 2'(ROM_LAT - 1);
  localparam logic [4:0] CODE_LIMIT = 5'(NUM_GLYPHS);
  localparam logic [4:0] ROW_LAST   = 5'(GLYPH_H - 1);
  localparam logic [3:0] COL_LAST   = 4'(GLYPH_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic [4:0]         code_q, code_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         fetch_cnt_q, fetch_cnt_d;
  logic [PIX_N-1:0]   shreg_q, shreg_d;
  logic [4:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;

  logic req_hs;
  logic pix_hs;
  logic at_last;

  assign req_hs  = req_valid & req_ready_q;
  assign pix_hs  = (state_q == ST_EMIT) & pix_ready;
  assign at_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    code_d      = code_q;
    addr_d      = addr_q;
    fetch_cnt_d = fetch_cnt_q;
    shreg_d     = shreg_q;
    row_d       = row_q;
    col_d       = col_q;

    case (state_q)
      ST_IDLE: begin
        // req_ready comes out of reset low and rises on the first edge.
        req_ready_d = 1'b1;
        if (req_hs) begin
          req_ready_d = 1'b0;
          code_d      = req_code;
          addr_d      = ADDR_W'(req_code);
          fetch_cnt_d = 2'd0;
          state_d     = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          // Codes past the glyph table render as a blank cell.
          shreg_d = (code_q < CODE_LIMIT) ? rom_data : '0;
          row_d   = 5'd0;
          col_d   = 4'd0;
          state_d = ST_EMIT;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 2'd1;
        end
      end

      ST_EMIT: begin
        if (pix_hs) begin
          shreg_d = shreg_q >> 1;
          if (col_q == COL_LAST) begin
            col_d = 4'd0;
            row_d = row_q + 5'd1;  // wraps to 0 after the last row
          end else begin
            col_d = col_q + 4'd1;
          end
          if (at_last) begin
            // Ready rises together with the return to IDLE so that the
            // next request can be taken one cycle later.
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      code_q      <= 5'd0;
      addr_q      <= '0;
      fetch_cnt_q <= 2'd0;
      shreg_q     <= '0;
      row_q       <= 5'd0;
      col_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      shreg_q     <= shreg_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rom_address = addr_q;
  assign pix_valid   = (state_q == ST_EMIT);
  assign pix_on      = shreg_q[0];
  assign pix_row     = row_q;
  assign pix_col     = col_q;
  assign pix_last    = (state_q == ST_EMIT) && at_last;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
`timescale 1ns/1ps
// Bench for glyph_pixel_streamer: ROM model, table of glyph requests
// checked through an expected-pixel queue, plus hand-written sequences for
// reset, back-to-back requests and reset in the middle of a glyph.
module tb_glyph_pixel_streamer;

  localparam int ROM_LAT = 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [4:0]   req_code = 5'd0;
  logic [9:0]   rom_address;
  logic [511:0] rom_data;
  logic         pix_valid;
  logic         pix_ready = 1'b0;
  logic         pix_on;
  logic [3:0]   pix_col;
  logic [4:0]   pix_row;
  logic         pix_last;
  logic         busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_pixel_streamer #(
    .GLYPH_W(16), .GLYPH_H(32), .ADDR_W(10), .NUM_GLYPHS(26), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
    .rom_address(rom_address), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
    .pix_col(pix_col), .pix_row(pix_row), .pix_last(pix_last), .busy(busy)
  );

  // Glyph ROM model: data follows the address combinationally.
  logic [511:0] rom_mem [0:31];
  assign rom_data = rom_mem[rom_address[4:0]];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];   // {on, row, col, last}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A pixel must never be offered while a new request can be accepted.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (pix_valid === 1'b1 && req_ready === 1'b1) begin
        n_fail++;
        $display("FAIL valid_ready_overlap: actual 1 required 0 (t=%0t)", $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(req_ready), 32'd1);
  endtask

  task automatic run_glyph(input logic [4:0] code, input logic stall,
                           input int exp_ones, input int exp_first);
    int n, hs, ones, first_v, first_on;
    logic prev_stall;
    logic [10:0] prev_out, e, act;
    logic [511:0] w;

    wait_ready("ready_before_req");
    w = (code < 5'd26) ? rom_mem[code] : '0;
    for (int k = 0; k < 512; k++)
      exp_q.push_back({w[k], 5'(k / 16), 4'(k % 16), (k == 511)});

    req_valid = 1'b1;
    req_code  = code;
    pix_ready = 1'b0;
    @(negedge clk);               // accept edge has passed: FETCH
    req_valid = 1'b0;
    req_code  = 5'($urandom_range(0, 31));
    check("rom_address", 32'(rom_address), 32'(code));
    check("fetch_valid", 32'(pix_valid), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_ready", 32'(req_ready), 32'd0);

    n = 1; hs = 0; ones = 0; first_v = -1; first_on = -1;
    prev_stall = 1'b0; prev_out = '0;
    while (hs < 512 && n < 5000) begin
      @(negedge clk);
      n++;
      act = {pix_on, pix_row, pix_col, pix_last};
      if (pix_valid && first_v < 0) first_v = n;
      if (prev_stall) check("hold_stable", 32'(act), 32'(prev_out));
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        e = exp_q.pop_front();
        check("pixel", 32'(act), 32'(e));
        if (pix_on && first_on < 0) first_on = hs;
        ones += int'(pix_on);
        hs++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = act;
    end
    check("handshakes", 32'(hs), 32'd512);
    check("first_valid_delay", 32'(first_v), 32'(ROM_LAT + 1));
    check("ones_count", 32'(ones), 32'(exp_ones));
    check("first_on_index", 32'(first_on), 32'(exp_first));
    exp_q.delete();

    @(negedge clk);
    pix_ready = 1'b0;
    check("end_valid", 32'(pix_valid), 32'd0);
    check("end_ready", 32'(req_ready), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_addr_hold", 32'(rom_address), 32'(code));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_on"}, 32'(pix_on), 32'd0);
    check({tag, "_pix_row"}, 32'(pix_row), 32'd0);
    check({tag, "_pix_col"}, 32'(pix_col), 32'd0);
    check({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rom_address"}, 32'(rom_address), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0] code;
    logic       stall;
    int         exp_ones;
    int         exp_first;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] w;
    int acc[2];
    int na, n, hs;

    for (int i = 0; i < 32; i++) rom_mem[i] = '0;
    rom_mem[3]  = 512'h1;
    w = '0; w[16*5+3] = 1'b1;
    rom_mem[5]  = w;
    rom_mem[7]  = {32{16'hA5A5}};
    rom_mem[25] = '1;
    rom_mem[30] = '1;

    // code, stall, ones expected, index of first foreground pixel
    vecs[0] = '{5'd3,  1'b0, 1,   0};
    vecs[1] = '{5'd5,  1'b0, 1,   83};
    vecs[2] = '{5'd7,  1'b0, 256, 0};
    vecs[3] = '{5'd7,  1'b1, 256, 0};
    vecs[4] = '{5'd5,  1'b1, 1,   83};
    vecs[5] = '{5'd25, 1'b0, 512, 0};
    vecs[6] = '{5'd30, 1'b0, 0,   -1};
    vecs[7] = '{5'd30, 1'b1, 0,   -1};

    // Reset asserted between clock edges; outputs must clear at once.
    #7 rst = 1'b1;
    #1 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++)
      run_glyph(vecs[i].code, vecs[i].stall, vecs[i].exp_ones, vecs[i].exp_first);

    // Back-to-back: request held high, consumer always ready.
    wait_ready("b2b_ready");
    req_valid = 1'b1;
    req_code  = 5'd3;
    pix_ready = 1'b1;
    na = 0; n = 0;
    while (na < 2 && n < 1500) begin
      if (req_valid && req_ready) begin
        acc[na] = cyc + 1;
        na++;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd2);
    if (na == 2) check("b2b_period", 32'(acc[1] - acc[0]), 32'(ROM_LAT + 513));
    wait_ready("b2b_drain");
    pix_ready = 1'b0;

    // Reset while pixel 200 is presented.
    wait_ready("rstmid_ready");
    req_valid = 1'b1;
    req_code  = 5'd25;
    @(negedge clk);
    req_valid = 1'b0;
    pix_ready = 1'b1;
    hs = 0; n = 0;
    while (hs < 200 && n < 1000) begin
      @(negedge clk);
      n++;
      if (pix_valid) hs++;
    end
    @(negedge clk);
    check("rstmid_row", 32'(pix_row), 32'd12);
    check("rstmid_col", 32'(pix_col), 32'd8);
    check("rstmid_valid", 32'(pix_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("rstmid");
    @(negedge clk);
    pix_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_back", 32'(req_ready), 32'd1);
    run_glyph(5'd3, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
